lsu_bus_ctrl: RTL and testbench
===============================

Name: lsu_bus_ctrl

Overview:
- Load/store unit directly downstream of the main controller's `dmem_wr_en` / load decode and the ALU address result.
- Turns a single-cycle core memory instruction into a multi-cycle req/ack data-bus transaction.
- Stalls the core until the transaction completes.
- Generates byte enables and store-lane replication; returns sign/zero-extended load data to the register-file write mux.

Parameters:
- TIMEOUT_CYCLES, 16, cycles in REQ without `bus_ack` before abort with error (min 1).
- CNT_W, 5, timeout counter width; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mem_rd  in  1  current instruction is LOAD.
- mem_wr  in  1  current instruction is STORE (controller `dmem_wr_en`).
- funct3  in  3  access size/sign.
- addr  in  32  byte address from ALU.
- wdata  in  32  store data (rs2).
- stall  out  1  hold PC and suppress RF write.
- ld_data  out  32  extended load result, valid when done=1.
- done  out  1  one-cycle completion pulse.
- bus_err  out  1  one-cycle pulse with done on timeout or misalign.
- bus_req  out  1  bus request.
- bus_we  out  1  1 = write.
- bus_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-replicated store data.
- bus_ack  in  1  bus completion; read data valid same cycle.
- bus_rdata  in  32  read word.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - All outputs 0: bus_req, bus_we, bus_addr, bus_be, bus_wdata, ld_data, done, bus_err.
  - stall=0 combinationally.
  - Asserting reset mid-transaction drops bus_req immediately; no completion pulse is produced.
- States: IDLE, REQ, DONE.
- IDLE:
  - stall = mem_rd|mem_wr (combinational).
  - On a request, register bus_addr/bus_we/bus_be/bus_wdata, the load funct3 and addr[1:0]; clear the counter; go to REQ.
  - mem_rd and mem_wr both set: treated as store.
- REQ:
  - bus_req=1; stall=1; all bus_* outputs held stable.
  - bus_ack=1: capture the extended load data into ld_data; go to DONE.
  - Else, counter == TIMEOUT_CYCLES-1: ld_data=0, set error; go to DONE.
  - Else increment the counter.
- DONE:
  - bus_req=0, stall=0, done=1, bus_err per the captured error.
  - Next state is always IDLE, ignoring mem_rd/mem_wr this cycle; the core commits here and its inputs still describe the same instruction.
- Latency:
  - Ack in the first REQ cycle → done 2 cycles after the request is first seen.
  - Each memory instruction therefore costs at least 3 cycles.
- Byte enables:
  - SB: 4'b0001<<addr[1:0].
  - SH: 4'b0011<<{addr[1],1'b0}.
  - SW: 4'b1111.
- Store data:
  - SB: {4{wdata[7:0]}}.
  - SH: {2{wdata[15:0]}}.
  - SW: wdata.
- Load data (selected by captured addr[1:0]):
  - LB 000: byte, sign-extended.
  - LH 001: halfword, sign-extended.
  - LW 010: full word.
  - LBU 100: byte, zero-extended.
  - LHU 101: halfword, zero-extended.
  - Any other funct3 is treated as LW/SW.
- Misaligned access:
  - Halfword with addr[0]=1, or word with addr[1:0]≠0.
  - Handled per the optional feature.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - A misaligned request goes IDLE→DONE directly; no bus_req is issued.
  - done=1, bus_err=1, ld_data=0.
  - Latency is 1 cycle after the request.
- Undefined:
  - Misalignment is ignored: addr low bits are masked (halfword addr[0]→0, word addr[1:0]→0).
  - The access proceeds normally with bus_err=0.

Test Plan:
- LW addr=0x100, bus_ack in the 1st REQ cycle, rdata=0xDEADBEEF:
  - bus_addr=0x100, be=1111.
  - done at cycle+2, ld_data=0xDEADBEEF, stall high exactly 2 cycles.
- SB addr=0x203, wdata=0x000000A5:
  - bus_we=1, be=1000, bus_wdata=0xA5A5A5A5, bus_addr=0x200.
- LB / LBU addr=0x301, rdata=0x0000_8000:
  - LB → ld_data=0xFFFFFF80.
  - LBU → 0x00000080.
  - LH at addr 0x302 with rdata=0x80000000 → 0xFFFF8000.
- LW with bus_ack held 0:
  - After 16 REQ cycles: done=1, bus_err=1, ld_data=0.
  - Then IDLE; bus_req low.
- rst_n pulled low during REQ:
  - bus_req=0 immediately, no done.
  - After release, a new SW to 0x10 completes normally.
- LH addr=0x401:
  - With macro: done+bus_err next cycle, bus_req never high.
  - Without macro: bus_addr=0x400, be=0011, bus_err=0.

Source files
------------

// File: rtl/lsu_bus_ctrl_if.sv
// Data-bus bundle between the load/store unit (master) and the memory side (slave).
// Read data and ack are sampled by the master in the same cycle.
interface lsu_bus_ctrl_if;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   modport master (
      output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
      input  bus_ack, bus_rdata
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
      output bus_ack, bus_rdata
   );
endinterface

// File: rtl/lsu_bus_ctrl.sv
// Load/store unit: one core LOAD/STORE becomes a req/ack bus transaction (LSU_MISALIGN_TRAP_EN traps misaligned accesses).
// Latency: done 2 cycles after the request on an immediate ack, 1 cycle on a misalign trap; abort after TIMEOUT_CYCLES in REQ.
// Backpressure: stall holds the core from request to done; bus_ack is the only bus-side flow control.
module lsu_bus_ctrl #(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_W          = 5
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           mem_rd,
   input  logic           mem_wr,
   input  logic [2:0]     funct3,
   input  logic [31:0]    addr,
   input  logic [31:0]    wdata,
   output logic           stall,
   output logic [31:0]    ld_data,
   output logic           done,
   output logic           bus_err,
   lsu_bus_ctrl_if.master bus
);
   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DONE} state_t;
   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             req_q, req_d;
   logic             we_q, we_d;
   logic [31:0]      baddr_q, baddr_d;
   logic [3:0]       be_q, be_d;
   logic [31:0]      bwdata_q, bwdata_d;
   size_t            ld_sz_q, ld_sz_d;
   logic             ld_uns_q, ld_uns_d;
   logic [1:0]       lo_q, lo_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic [31:0]      ld_q, ld_d;

   size_t       sz;
   logic [1:0]  lo;
   logic [3:0]  be_new;
   logic [31:0] wdata_new;
   logic [7:0]  rd_byte;
   logic [15:0] rd_half;
   logic [31:0] ld_ext;
   logic        trap;

   // Stores win when both strobes are set; funct3[2] only means "unsigned" for loads.
   always_comb begin
      sz = SZ_W;
      if (mem_wr) begin
         if (funct3 == 3'b000)      sz = SZ_B;
         else if (funct3 == 3'b001) sz = SZ_H;
      end else begin
         if (funct3[1:0] == 2'b00)      sz = SZ_B;
         else if (funct3[1:0] == 2'b01) sz = SZ_H;
      end
      lo        = 2'b00;
      be_new    = 4'b1111;
      wdata_new = wdata;
      case (sz)
         SZ_B: begin
            lo        = addr[1:0];
            be_new    = 4'b0001 << addr[1:0];
            wdata_new = {4{wdata[7:0]}};
         end
         SZ_H: begin
            lo        = {addr[1], 1'b0};
            be_new    = 4'b0011 << {addr[1], 1'b0};
            wdata_new = {2{wdata[15:0]}};
         end
         default: ;
      endcase
   end

`ifdef LSU_MISALIGN_TRAP_EN
   assign trap = ((sz == SZ_H) && addr[0]) || ((sz == SZ_W) && (addr[1:0] != 2'b00));
`else
   assign trap = 1'b0;
`endif

   always_comb begin
      rd_byte = bus.bus_rdata[7:0];
      case (lo_q)
         2'd1:    rd_byte = bus.bus_rdata[15:8];
         2'd2:    rd_byte = bus.bus_rdata[23:16];
         2'd3:    rd_byte = bus.bus_rdata[31:24];
         default: rd_byte = bus.bus_rdata[7:0];
      endcase
      rd_half = lo_q[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
      case (ld_sz_q)
         SZ_B:    ld_ext = ld_uns_q ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
         SZ_H:    ld_ext = ld_uns_q ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
         default: ld_ext = bus.bus_rdata;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      req_d    = req_q;
      we_d     = we_q;
      baddr_d  = baddr_q;
      be_d     = be_q;
      bwdata_d = bwdata_q;
      ld_sz_d  = ld_sz_q;
      ld_uns_d = ld_uns_q;
      lo_d     = lo_q;
      ld_d     = ld_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      stall    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            stall = rst_n & (mem_rd | mem_wr);
            if (mem_rd || mem_wr) begin
               if (trap) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
                  err_d   = 1'b1;
                  ld_d    = '0;
               end else begin
                  state_d  = ST_REQ;
                  cnt_d    = '0;
                  req_d    = 1'b1;
                  we_d     = mem_wr;
                  baddr_d  = {addr[31:2], 2'b00};
                  be_d     = be_new;
                  bwdata_d = wdata_new;
                  ld_sz_d  = sz;
                  ld_uns_d = funct3[2];
                  lo_d     = lo;
               end
            end
         end
         ST_REQ: begin
            stall = rst_n;
            if (bus.bus_ack) begin
               state_d = ST_DONE;
               req_d   = 1'b0;
               done_d  = 1'b1;
               ld_d    = ld_ext;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_DONE;
               req_d   = 1'b0;
               done_d  = 1'b1;
               err_d   = 1'b1;
               ld_d    = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         // The core commits this cycle with the same instruction still on its inputs.
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         req_q    <= 1'b0;
         we_q     <= 1'b0;
         baddr_q  <= '0;
         be_q     <= '0;
         bwdata_q <= '0;
         ld_sz_q  <= SZ_W;
         ld_uns_q <= 1'b0;
         lo_q     <= '0;
         ld_q     <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         req_q    <= req_d;
         we_q     <= we_d;
         baddr_q  <= baddr_d;
         be_q     <= be_d;
         bwdata_q <= bwdata_d;
         ld_sz_q  <= ld_sz_d;
         ld_uns_q <= ld_uns_d;
         lo_q     <= lo_d;
         ld_q     <= ld_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   assign bus.bus_req   = req_q;
   assign bus.bus_we    = we_q;
   assign bus.bus_addr  = baddr_q;
   assign bus.bus_be    = be_q;
   assign bus.bus_wdata = bwdata_q;
   assign ld_data       = ld_q;
   assign done          = done_q;
   assign bus_err       = err_q;
endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Bench for lsu_bus_ctrl: fixed vectors, reset abort sequence, then random transactions against an arithmetic model.
// Builds with or without LSU_MISALIGN_TRAP_EN; expectations follow the macro.
module tb_lsu_bus_ctrl;
   localparam int TMO = 16;
`ifdef LSU_MISALIGN_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   typedef struct packed {
      logic        rd;
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] rdat;
      int          ackw;
      logic        e_req;
      logic        e_we;
      logic [31:0] e_addr;
      logic [3:0]  e_be;
      logic [31:0] e_wdata;
      logic [31:0] e_ld;
      logic        e_err;
      int          e_lat;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_rd, mem_wr;
   logic [2:0]  funct3;
   logic [31:0] addr, wdata;
   logic        stall, done, bus_err;
   logic [31:0] ld_data;
   int          checks = 0;
   int          errors = 0;

   lsu_bus_ctrl_if bif ();

   lsu_bus_ctrl #(.TIMEOUT_CYCLES(TMO), .CNT_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .mem_rd(mem_rd), .mem_wr(mem_wr), .funct3(funct3),
      .addr(addr), .wdata(wdata), .stall(stall), .ld_data(ld_data), .done(done),
      .bus_err(bus_err), .bus(bif)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s got %h want %h", nm, act, want);
      end
   endtask

   // Expected outcome from access size, offset and timeout rules.
   function automatic vec_t model(input vec_t v);
      vec_t r = v;
      int sz, off, eff;
      bit mis, trap, tmo;
      longint unsigned mask, val;
      if (v.wr) sz = (v.f3 == 3'd0) ? 1 : (v.f3 == 3'd1) ? 2 : 4;
      else      sz = (v.f3[1:0] == 2'd0) ? 1 : (v.f3[1:0] == 2'd1) ? 2 : 4;
      off  = int'(v.a % 4);
      mis  = (off % sz) != 0;
      eff  = off - (off % sz);
      trap = mis && TRAP_EN;
      tmo  = !trap && (v.ackw >= TMO);
      r.e_req  = !trap;
      r.e_we   = v.wr;
      r.e_addr = v.a & 32'hFFFF_FFFC;
      r.e_be   = 4'(((1 << sz) - 1) << eff);
      for (int i = 0; i < 4; i++) r.e_wdata[8*i +: 8] = v.wd[8*(i % sz) +: 8];
      mask = (64'd1 << (8 * sz)) - 64'd1;
      val  = (64'(v.rdat) >> (8 * eff)) & mask;
      if (sz < 4 && !v.f3[2] && val[8*sz-1]) val = val | ~mask;
      r.e_err = trap || tmo;
      r.e_ld  = r.e_err ? 32'h0 : val[31:0];
      r.e_lat = trap ? 1 : tmo ? 1 + TMO : 2 + v.ackw;
      return r;
   endfunction

   task automatic run_txn(input vec_t v, input string tag);
      int cyc, reqc, stc;
      bit seen, got;
      @(negedge clk);
      mem_rd = v.rd; mem_wr = v.wr; funct3 = v.f3; addr = v.a; wdata = v.wd;
      bif.bus_ack = 1'b0; bif.bus_rdata = v.rdat;
      #1;
      stc = stall ? 1 : 0;
      cyc = 0; reqc = 0; seen = 1'b0; got = 1'b0;
      while (!got && cyc < 40) begin
         @(negedge clk);
         cyc++;
         bif.bus_ack = 1'b0;
         if (done) got = 1'b1;
         else begin
            if (stall) stc++;
            if (bif.bus_req) begin
               if (!seen) begin
                  chk({tag, " bus_addr"}, bif.bus_addr, v.e_addr);
                  chk({tag, " bus_be"}, 32'(bif.bus_be), 32'(v.e_be));
                  chk({tag, " bus_we"}, 32'(bif.bus_we), 32'(v.e_we));
                  if (v.wr) chk({tag, " bus_wdata"}, bif.bus_wdata, v.e_wdata);
               end
               seen = 1'b1;
               if (reqc == v.ackw) bif.bus_ack = 1'b1;
               reqc++;
            end
         end
      end
      chk({tag, " done_seen"}, 32'(got), 32'd1);
      chk({tag, " latency"}, 32'(cyc), 32'(v.e_lat));
      chk({tag, " stall_cycles"}, 32'(stc), 32'(v.e_lat));
      chk({tag, " req_issued"}, 32'(seen), 32'(v.e_req));
      chk({tag, " stall_in_done"}, 32'(stall), 32'd0);
      chk({tag, " req_in_done"}, 32'(bif.bus_req), 32'd0);
      chk({tag, " bus_err"}, 32'(bus_err), 32'(v.e_err));
      if (!v.wr || v.e_err) chk({tag, " ld_data"}, ld_data, v.e_ld);
      @(negedge clk);
      mem_rd = 1'b0; mem_wr = 1'b0; bif.bus_ack = 1'b0;
      #1;
      chk({tag, " done_pulse"}, 32'(done), 32'd0);
      chk({tag, " err_pulse"}, 32'(bus_err), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[13];
      vec_t v;
      int   r;

      tbl[0]  = '{1'b1,1'b0,3'b010,32'h100,32'h0,32'hDEADBEEF,0,           1'b1,1'b0,32'h100,4'hF,32'h0,32'hDEADBEEF,1'b0,2};
      tbl[1]  = '{1'b0,1'b1,3'b000,32'h203,32'hA5,32'h0,1,                 1'b1,1'b1,32'h200,4'h8,32'hA5A5A5A5,32'h0,1'b0,3};
      tbl[2]  = '{1'b1,1'b0,3'b000,32'h301,32'h0,32'h00008000,0,           1'b1,1'b0,32'h300,4'h2,32'h0,32'hFFFFFF80,1'b0,2};
      tbl[3]  = '{1'b1,1'b0,3'b100,32'h301,32'h0,32'h00008000,2,           1'b1,1'b0,32'h300,4'h2,32'h0,32'h00000080,1'b0,4};
      tbl[4]  = '{1'b1,1'b0,3'b001,32'h302,32'h0,32'h80000000,0,           1'b1,1'b0,32'h300,4'hC,32'h0,32'hFFFF8000,1'b0,2};
      tbl[5]  = '{1'b1,1'b0,3'b010,32'h500,32'h0,32'h12345678,1000,        1'b1,1'b0,32'h500,4'hF,32'h0,32'h0,1'b1,17};
`ifdef LSU_MISALIGN_TRAP_EN
      tbl[6]  = '{1'b1,1'b0,3'b001,32'h401,32'h0,32'h1234ABCD,0,           1'b0,1'b0,32'h0,4'h0,32'h0,32'h0,1'b1,1};
      tbl[9]  = '{1'b0,1'b1,3'b010,32'h20A,32'h11223344,32'h0,0,           1'b0,1'b1,32'h0,4'h0,32'h0,32'h0,1'b1,1};
`else
      tbl[6]  = '{1'b1,1'b0,3'b001,32'h401,32'h0,32'h1234ABCD,0,           1'b1,1'b0,32'h400,4'h3,32'h0,32'hFFFFABCD,1'b0,2};
      tbl[9]  = '{1'b0,1'b1,3'b010,32'h20A,32'h11223344,32'h0,0,           1'b1,1'b1,32'h208,4'hF,32'h11223344,32'h0,1'b0,2};
`endif
      tbl[7]  = '{1'b0,1'b1,3'b001,32'h106,32'h1234BEEF,32'h0,0,           1'b1,1'b1,32'h104,4'hC,32'hBEEFBEEF,32'h0,1'b0,2};
      tbl[8]  = '{1'b1,1'b0,3'b101,32'h102,32'h0,32'h9ABC0000,3,           1'b1,1'b0,32'h100,4'hC,32'h0,32'h00009ABC,1'b0,5};
      tbl[10] = '{1'b1,1'b1,3'b000,32'h7,32'h5A,32'h0,0,                   1'b1,1'b1,32'h4,4'h8,32'h5A5A5A5A,32'h0,1'b0,2};
      tbl[11] = '{1'b1,1'b0,3'b010,32'h600,32'h0,32'hCAFEF00D,15,          1'b1,1'b0,32'h600,4'hF,32'h0,32'hCAFEF00D,1'b0,17};
      tbl[12] = '{1'b1,1'b0,3'b000,32'h303,32'h0,32'h7F000000,0,           1'b1,1'b0,32'h300,4'h8,32'h0,32'h0000007F,1'b0,2};

      rst_n = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; funct3 = 3'b0; addr = '0; wdata = '0;
      bif.bus_ack = 1'b0; bif.bus_rdata = '0;
      #1;
      chk("rst stall", 32'(stall), 32'd0);
      chk("rst bus_req", 32'(bif.bus_req), 32'd0);
      chk("rst bus_we", 32'(bif.bus_we), 32'd0);
      chk("rst bus_addr", bif.bus_addr, 32'd0);
      chk("rst bus_be", 32'(bif.bus_be), 32'd0);
      chk("rst bus_wdata", bif.bus_wdata, 32'd0);
      chk("rst ld_data", ld_data, 32'd0);
      chk("rst done", 32'(done), 32'd0);
      chk("rst bus_err", 32'(bus_err), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 13; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

      // Reset pulled mid-REQ: request drops at once, no completion.
      @(negedge clk);
      mem_rd = 1'b1; funct3 = 3'b010; addr = 32'h800;
      @(negedge clk);
      chk("rstmid req_before", 32'(bif.bus_req), 32'd1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rstmid bus_req", 32'(bif.bus_req), 32'd0);
      chk("rstmid stall", 32'(stall), 32'd0);
      chk("rstmid done", 32'(done), 32'd0);
      chk("rstmid bus_addr", bif.bus_addr, 32'd0);
      repeat (2) begin
         @(negedge clk);
         chk("rstmid no_done", 32'(done), 32'd0);
      end
      mem_rd = 1'b0;
      rst_n = 1'b1;
      v = '0;
      v.wr = 1'b1; v.f3 = 3'b010; v.a = 32'h10; v.wd = 32'h0BADF00D; v.ackw = 1;
      run_txn(model(v), "post_rst_sw");

      for (int n = 0; n < 150; n++) begin
         r      = $urandom_range(1, 3);
         v      = '0;
         v.rd   = r[0];
         v.wr   = r[1];
         v.f3   = 3'($urandom_range(0, 7));
         v.a    = $urandom;
         v.wd   = $urandom;
         v.rdat = $urandom;
         v.ackw = $urandom_range(0, 19);
         run_txn(model(v), $sformatf("rnd%0d", n));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
